// File: rtl/lcd_pkg.sv
// Shared types, init ROM and timing-counter width for the HD44780 write-only sequencer.
`timescale 1ns/1ps
package lcd_pkg;

  localparam int LCD_CNT_W    = 20;
  localparam int LCD_INIT_LEN = 4;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_SETUP,
    ST_EHI,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_t;

  // One bus write: register select plus the byte on DB[7:0].
  typedef struct packed {
    logic       rs;
    logic [7:0] dat;
  } lcd_byte_t;

  function automatic lcd_byte_t lcd_init_rom(input logic [1:0] idx);
    lcd_byte_t b;
    b.rs  = 1'b0;
    b.dat = LCD_FUNC_SET;
    case (idx)
      2'd0: b.dat = LCD_FUNC_SET;
      2'd1: b.dat = LCD_DISP_ON;
      2'd2: b.dat = LCD_CLEAR;
      2'd3: b.dat = LCD_ENTRY;
      default: b.dat = LCD_FUNC_SET;
    endcase
    return b;
  endfunction

  // Clear (0x01) and Home (0x02/0x03) are the only slow instructions.
  function automatic logic lcd_is_long(input lcd_byte_t b);
    return !b.rs && (b.dat[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write sequencer: power-up wait, 4-byte init, then user writes via valid/ready.
// req_ready returns 2+E_CYC+delay cycles after a transfer; no queueing, requester holds req_valid.
`timescale 1ns/1ps
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC = 750000,
  parameter int E_CYC       = 12,
  parameter int SHORT_CYC   = 2000,
  parameter int LONG_CYC    = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  localparam logic [LCD_CNT_W-1:0] PWR_LOAD   = LCD_CNT_W'(POWERUP_CYC - 1);
  localparam logic [LCD_CNT_W-1:0] E_LOAD     = LCD_CNT_W'(E_CYC - 1);
  localparam logic [LCD_CNT_W-1:0] SHORT_LOAD = LCD_CNT_W'(SHORT_CYC - 1);
  localparam logic [LCD_CNT_W-1:0] LONG_LOAD  = LCD_CNT_W'(LONG_CYC - 1);
  localparam logic [1:0]           INIT_LAST  = 2'(LCD_INIT_LEN - 1);

  lcd_state_t           state;
  logic [LCD_CNT_W-1:0] cnt;
  logic [1:0]           init_idx;
  logic [1:0]           init_nxt;
  logic                 cnt_zero;
  lcd_byte_t            cur;

  assign cnt_zero = (cnt == '0);
  assign init_nxt = init_idx + 2'd1;
  assign lcd_db   = cur.dat;
  assign lcd_rs   = cur.rs;
  assign lcd_rw   = 1'b0;

  // One down-counter times power-up, the E pulse and the execution wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PWR;
      cnt       <= PWR_LOAD;
      init_idx  <= '0;
      init_done <= 1'b0;
      req_ready <= 1'b0;
      lcd_e     <= 1'b0;
      cur       <= '0;
    end else begin
      case (state)
        ST_PWR: begin
          if (cnt_zero) begin
            state    <= ST_SETUP;
            init_idx <= '0;
            cur      <= lcd_init_rom(2'd0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SETUP: begin
          state <= ST_EHI;
          lcd_e <= 1'b1;
          cnt   <= E_LOAD;
        end
        ST_EHI: begin
          if (cnt_zero) begin
            state <= ST_HOLD;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          state <= ST_WAIT;
          cnt   <= lcd_is_long(cur) ? LONG_LOAD : SHORT_LOAD;
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            if (!init_done && init_idx != INIT_LAST) begin
              state    <= ST_SETUP;
              init_idx <= init_nxt;
              cur      <= lcd_init_rom(init_nxt);
            end else begin
              state     <= ST_IDLE;
              init_done <= 1'b1;
              req_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_SETUP;
            req_ready <= 1'b0;
            cur.rs    <= req_rs;
            cur.dat   <= req_data;
          end
        end
        default: begin
          state <= ST_PWR;
          cnt   <= PWR_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: timeline model checked every cycle plus literal timing/byte checks.
`timescale 1ns/1ps
module tb_lcd_ctrl;

  localparam int P  = 20;
  localparam int E  = 3;
  localparam int SH = 5;
  localparam int LG = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       init_done;
  logic [7:0] lcd_db;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  lcd_ctrl #(
    .POWERUP_CYC(P),
    .E_CYC      (E),
    .SHORT_CYC  (SH),
    .LONG_CYC   (LG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_ready(req_ready),
    .init_done(init_done),
    .lcd_db   (lcd_db),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  bit [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  int       cyc = 0;
  int       rel = 0;
  bit       m_on = 0;
  bit       m_rst_last = 0;
  bit       m_busy, m_ready, m_done;
  bit [8:0] m_byte;
  int       m_t0, m_d, m_n_init, m_pwr_end;

  function automatic int delay_of(input bit [8:0] b);
    return (b[8] == 1'b0 && b[7:0] < 8'd4) ? LG : SH;
  endfunction

  task automatic m_start(input bit [8:0] b);
    m_busy = 1; m_t0 = cyc; m_byte = b; m_d = delay_of(b);
  endtask

  always @(posedge clk) begin
    cyc++;
    m_rst_last = rst;
    if (rst) begin
      rel = 0; m_on = 1; m_busy = 0; m_ready = 0; m_done = 0; m_byte = '0;
      m_n_init = 0; m_pwr_end = cyc + P;
    end else if (m_on) begin
      rel++;
      if (!m_busy && m_n_init == 0 && cyc == m_pwr_end) begin
        m_start({1'b0, init_seq[0]}); m_n_init = 1;
      end else if (m_busy && cyc == m_t0 + 2 + E + m_d) begin
        m_busy = 0;
        if (m_n_init < 4) begin
          m_start({1'b0, init_seq[m_n_init]}); m_n_init++;
        end else begin
          m_ready = 1; m_done = 1;
        end
      end else if (m_ready && req_valid) begin
        m_ready = 0; m_start({req_rs, req_data});
      end
    end
  end

  // ---------------- per-cycle compare and pin monitor ----------------
  bit       prev_e = 0;
  bit [8:0] prev_bus = '0;
  int       w = 0;
  bit [8:0] cap_b[$];
  int       cap_rel[$];
  int       cap_w[$];

  always @(negedge clk) begin
    if (m_on) begin
      bit exp_e;
      exp_e = m_busy && (cyc - m_t0 >= 1) && (cyc - m_t0 <= E);
      n_vec++;
      if (lcd_e !== exp_e || {lcd_rs, lcd_db} !== m_byte || req_ready !== m_ready ||
          init_done !== m_done || lcd_rw !== 1'b0) begin
        n_bad++;
        $display("FAIL cycle %0d: e=%b rs=%b db=%h rdy=%b done=%b rw=%b, expected e=%b rs=%b db=%h rdy=%b done=%b rw=0",
                 cyc, lcd_e, lcd_rs, lcd_db, req_ready, init_done, lcd_rw,
                 exp_e, m_byte[8], m_byte[7:0], m_ready, m_done);
      end
      // Bus must not move while E is high, nor on the cycles adjoining the pulse.
      if (!m_rst_last && (lcd_e || prev_e)) chk("bus_stable", {lcd_rs, lcd_db}, prev_bus);
      if (lcd_e && !prev_e) begin
        cap_b.push_back({lcd_rs, lcd_db}); cap_rel.push_back(rel); w = 0;
      end
      if (lcd_e) w++;
      if (!lcd_e && prev_e) cap_w.push_back(w);
    end
    prev_e   = lcd_e;
    prev_bus = {lcd_rs, lcd_db};
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit rs, input bit [7:0] d, output int hs_rel);
    req_valid = 1; req_rs = rs; req_data = d;
    for (int i = 0; i < 400 && !req_ready; i++) @(negedge clk);
    chk("handshake_timeout", req_ready, 1);
    @(posedge clk);
    #1;
    hs_rel = rel;
    req_valid = 0;
  endtask

  task automatic measure_low(output int low);
    low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) break;
      low++;
    end
  endtask

  task automatic wait_done(output int r);
    for (int i = 0; i < 400 && !init_done; i++) @(negedge clk);
    chk("init_done_timeout", init_done, 1);
    r = rel;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic check_init(input int base, input string tag);
    int r;
    wait_done(r);
    chk({tag, "_done_rel"}, r, 70);
    chk({tag, "_ready_with_done"}, req_ready, 1);
    chk({tag, "_first_rise"}, cap_rel[base], P + 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), cap_b[base+i], {1'b0, init_seq[i]});
      chk($sformatf("%s_width%0d", tag, i), cap_w[base+i], E);
    end
    chk({tag, "_gap0"}, cap_rel[base+1] - cap_rel[base], 2 + E + SH);
    chk({tag, "_gap1"}, cap_rel[base+2] - cap_rel[base+1], 2 + E + SH);
    chk({tag, "_gap2"}, cap_rel[base+3] - cap_rel[base+2], 2 + E + LG);
    chk({tag, "_count"}, cap_b.size(), base + 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit [8:0] tbl_b  [4] = '{9'h002, 9'h003, 9'h004, 9'h101};
  int       tbl_low[4] = '{20, 20, 10, 10};

  initial begin
    int hs, hs2, low, base;
    rst = 1; req_valid = 0; req_rs = 0; req_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Power-up and init with no requests.
    check_init(0, "init");

    // Re-init with a request held throughout; it must wait for init_done.
    pulse_rst();
    chk("rst_done_low", init_done, 0);
    chk("rst_ready_low", req_ready, 0);
    base = cap_b.size();
    send(1'b1, 8'h41, hs);
    chk("held_hs_rel", hs, 71);
    measure_low(low);
    chk("held_low", low, 10);
    chk("held_byte", cap_b[base+4], 9'h141);
    chk("held_rise_rel", cap_rel[base+4], 72);

    // Back-to-back: data byte then clear.
    send(1'b1, 8'h41, hs);
    measure_low(low);
    chk("b2b_low_data", low, 10);
    send(1'b0, 8'h01, hs2);
    chk("b2b_period", hs2 - hs, 3 + E + SH);
    measure_low(low);
    chk("b2b_low_clear", low, 20);

    // Long/short delay classification.
    for (int i = 0; i < 4; i++) begin
      send(tbl_b[i][8], tbl_b[i][7:0], hs);
      measure_low(low);
      chk($sformatf("delay_low_%03h", tbl_b[i]), low, tbl_low[i]);
      chk($sformatf("delay_byte_%03h", tbl_b[i]), cap_b[cap_b.size()-1], tbl_b[i]);
    end

    // Reset during the E pulse of a user write.
    send(1'b0, 8'h80, hs);
    @(posedge clk); #1;
    chk("abort_e_high", lcd_e, 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("abort_e_low", lcd_e, 0);
    chk("abort_done_low", init_done, 0);
    base = cap_b.size();
    check_init(base, "reinit");
    repeat (5) @(negedge clk);
    chk("abort_not_reissued", cap_b.size(), base + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Sequencer for an HD44780-compatible character LCD in 8-bit write-only mode. After reset it waits out the panel power-up time, plays a fixed four-command init sequence, then accepts command/data bytes from the user logic over a valid/ready handshake. Each byte is issued as a full bus write: setup, timed E pulse, hold, then the controller-execution delay. It sits between the text/cursor logic and the LCD pins and owns the E-pulse timing and all busy-wait timing.

## Interface
- `POWERUP_CYC`, default 750000: clocks to wait after reset before the first write (15 ms at 50 MHz).
- `E_CYC`, default 12: clocks `lcd_e` stays high per write (≥230 ns); must be ≥1.
- `SHORT_CYC`, default 2000: execution wait after ordinary writes (40 µs).
- `LONG_CYC`, default 82000: execution wait after Clear (0x01) and Home (0x02/0x03) commands (1.64 ms).
- All cycle parameters must be ≤ 2^20−1.
- `clk` in 1: system clock; all logic runs on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a user byte is offered.
- `req_rs` in 1: 0 means command, 1 means data (DDRAM/CGRAM write).
- `req_data` in 8: byte to write.
- `req_ready` out 1: controller accepts a byte this cycle.
- `init_done` out 1: init sequence complete; stays high until reset.
- `lcd_db` out 8: LCD data bus.
- `lcd_rs` out 1: LCD register select.
- `lcd_rw` out 1: tied to 0 (write only).
- `lcd_e` out 1: LCD enable strobe, registered.

## Operation
- Reset values: `req_ready`=0, `init_done`=0, `lcd_e`=0, `lcd_db`=0x00, `lcd_rs`=0, `lcd_rw`=0.
- States:
  - **PWR**: count `POWERUP_CYC` cycles, then go to SETUP with init entry 0.
  - **SETUP**: 1 cycle. `lcd_db`/`lcd_rs` are driven with the current byte.
  - **EHI**: `E_CYC` cycles with `lcd_e`=1.
  - **HOLD**: 1 cycle with `lcd_e`=0 and the bus held.
  - **WAIT**: `LONG_CYC` or `SHORT_CYC` cycles. After WAIT:
    - If the init index is below 3, advance the index and go to SETUP.
    - If the init index is 3, set `init_done` and go to IDLE.
    - Otherwise go to IDLE.
  - **IDLE**: `req_ready`=1. If `req_valid`, capture `req_rs`/`req_data` and go to SETUP.
- Init ROM, in order, all with rs=0: 0x38 (8-bit, 2-line, 5x8), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (increment, no shift).
- Long delay rule: rs=0 and `data[7:2]==0` (clear or home). Every other byte gets the short delay.
- `lcd_db`/`lcd_rs` hold their value from SETUP through WAIT and keep the last value in IDLE.
- The bus never changes while `lcd_e`=1.
- `req_ready`=0 outside IDLE, including during the whole init phase. Requests are not queued; the requester holds `req_valid` until a handshake occurs.
- A single 20-bit down-counter serves PWR, EHI and WAIT: it loads (N−1) and the state exits when the count reaches 0.
- `rst` in any state, including mid-pulse, forces PWR on the next edge: `lcd_e` goes to 0 and the full power-up and init sequence reruns.

## Timing
- Handshake: transfer occurs on the edge where `req_valid` && `req_ready`.
- After the transfer edge: SETUP for 1 cycle, `lcd_e` high for `E_CYC` cycles, HOLD for 1 cycle, WAIT for `SHORT_CYC`/`LONG_CYC` cycles.
- `req_ready` returns after 2+`E_CYC`+delay cycles from the transfer.
- Max throughput: one byte per 3+`E_CYC`+delay cycles.
- First `lcd_e` rise occurs `POWERUP_CYC`+1 cycles after reset is released.
- `init_done` and `req_ready` rise in the same cycle.

## Structure
- Shared package `lcd_pkg`:
  - state enum
  - init ROM constants (`LCD_FUNC_SET`=0x38, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01, `LCD_ENTRY`=0x06)
  - `LCD_INIT_LEN`=4
  - counter width constant 20
- Single FSM module. No sub-module: the E-pulse timing is folded into the shared counter rather than instantiated as a separate strobe block.

## Test plan
All scenarios use POWERUP_CYC=20, E_CYC=3, SHORT_CYC=5, LONG_CYC=15.
- Reset release with `req_valid`=0:
  - first `lcd_e` rise at cycle 21;
  - bytes 0x38, 0x0C, 0x01, 0x06 appear with rs=0;
  - each E pulse is exactly 3 cycles;
  - gaps use delays 5, 5, 15, 5;
  - `init_done`=`req_ready`=1 after the last wait.
- During init, hold `req_valid`=1 with data 0x41, rs=1 → no handshake before `init_done`; 0x41 is written with rs=1 immediately after.
- Send 0x41 (rs=1) then 0x01 (rs=0) back-to-back → `req_ready` low for 10 cycles, then for 20 cycles.
- Send 0x02 and 0x03 with rs=0 → long wait. Send 0x04 with rs=0, and 0x01 with rs=1 → short wait.
- Bus check on every write → `lcd_db`/`lcd_rs` stable on every cycle with `lcd_e`=1 and on the cycle before and after; `lcd_rw`=0 throughout.
- Assert `rst` for 1 cycle during EHI of a user write → `lcd_e`=0 and `init_done`=0 next cycle; power-up wait and init sequence restart; the aborted byte is not reissued.
